// File: rtl/pmod_pixel_streamer_if.sv
// Pixel-in / PMOD-out signal bundle for the pixel streamer.
// slave  : the streamer's view (consumes pixels and ack, drives the PMOD bus)
// master : the environment's view (camera side and external receiver)
interface pmod_pixel_streamer_if;
  logic [18:0] pix_addr_i;
  logic [3:0]  pix_data_i;
  logic        pix_wr_i;
  logic [7:0]  pmod_data_o;
  logic        pmod_sof_o;
  logic        pmod_stb_o;
  logic        pmod_ack_i;

  modport slave (
    input  pix_addr_i, pix_data_i, pix_wr_i, pmod_ack_i,
    output pmod_data_o, pmod_sof_o, pmod_stb_o
  );

  modport master (
    output pix_addr_i, pix_data_i, pix_wr_i, pmod_ack_i,
    input  pmod_data_o, pmod_sof_o, pmod_stb_o
  );
endinterface

// File: rtl/pmod_pixel_streamer.sv
// Packs 4-bit pixel pairs into bytes, buffers them in a small FIFO and
// ships them over an 8-bit PMOD bus with a 4-phase strobe/ack handshake.
// FIFO entry = {sof, byte}; byte = {odd pixel, even pixel}.
module pmod_pixel_streamer #(
  parameter int FIFO_DEPTH_G  = 16,
  parameter int SETUP_HOLD_G  = 4,
  parameter int ACK_TIMEOUT_G = 1_000_000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  pmod_pixel_streamer_if.slave              bus,
  output logic                              overflow_o,
  output logic                              timeout_o,
  output logic [$clog2(FIFO_DEPTH_G):0]     fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH_G);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT_G + SETUP_HOLD_G + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STB, RELEASE} state_t;

  // ack synchroniser
  logic ack_meta_q, ack_s_q;

  // packer state
  logic [3:0] held_q;
  logic       pend_q;
  logic       sofp_q;

  // FIFO state
  logic [8:0]    mem_q [FIFO_DEPTH_G];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  // output FSM state
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    data_q;
  logic          sof_q;
  logic          stb_q;

  logic overflow_q, timeout_q;

  logic wr_even, push, full, empty, pop, push_ok, drop, tmo_hit;
  logic [8:0] push_word;

  // Datapath decode: a pair completes on an odd write with a nibble held.
  // When full, a same-edge pop frees the slot, so the push still lands.
  always_comb begin
    wr_even   = bus.pix_wr_i & ~bus.pix_addr_i[0];
    push      = bus.pix_wr_i &  bus.pix_addr_i[0] & pend_q;
    full      = (level_q == LW'(FIFO_DEPTH_G));
    empty     = (level_q == '0);
    pop       = (state_q == IDLE) & ~empty;
    push_ok   = push & (~full | pop);
    drop      = push & ~push_ok;
    push_word = {sofp_q, bus.pix_data_i, held_q};
    // An ack seen in STB wins over a timeout on the same cycle.
    tmo_hit   = ((state_q == STB && !ack_s_q) || (state_q == RELEASE && ack_s_q))
                && (cnt_q == CW'(ACK_TIMEOUT_G - 1));
    level_d   = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Two-flop synchroniser for the asynchronous receiver ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= bus.pmod_ack_i;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Packer: hold even nibble, pair it with the next odd one; track frame start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q <= '0;
      pend_q <= 1'b0;
      sofp_q <= 1'b0;
    end else if (wr_even) begin
      held_q <= bus.pix_data_i;
      pend_q <= 1'b1;
      if (bus.pix_addr_i == '0) sofp_q <= 1'b1;
    end else if (push) begin
      pend_q <= 1'b0;
      // a dropped frame-start byte leaves the flag for the next byte
      if (push_ok) sofp_q <= 1'b0;
    end
  end

  // FIFO storage, no reset needed: occupancy is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Sticky error flags; a pushed frame-start byte clears them
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (push_ok && sofp_q) begin
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
      end
      if (drop)    overflow_q <= 1'b1;
      if (tmo_hit) timeout_q  <= 1'b1;
    end
  end

  // Output handshake FSM; data/sof only change when a byte is popped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            data_q  <= mem_q[rd_ptr_q][7:0];
            sof_q   <= mem_q[rd_ptr_q][8];
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == CW'(SETUP_HOLD_G - 1)) begin
            cnt_q   <= '0;
            stb_q   <= 1'b1;
            state_q <= STB;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STB: begin
          if (ack_s_q) begin
            stb_q   <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            state_q <= RELEASE;
          end else if (tmo_hit) begin
            stb_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (!ack_s_q || tmo_hit) state_q <= IDLE;
          else                     cnt_q   <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pmod_data_o = data_q;
  assign bus.pmod_sof_o  = sof_q;
  assign bus.pmod_stb_o  = stb_q;
  assign overflow_o      = overflow_q;
  assign timeout_o       = timeout_q;
  assign fifo_level_o    = level_q;

endmodule

// File: tb/tb_pmod_pixel_streamer.sv
// Directed bench for pmod_pixel_streamer: stimulus queues expected
// {sof, byte} words; a monitor pops one on every strobe rising edge.
module tb_pmod_pixel_streamer;

  localparam int DEPTH = 16;
  localparam int SH    = 4;
  localparam int TO    = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       ovf, tmo;
  logic [4:0] lvl;
  logic       ack_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int max_lvl = 0;
  logic [8:0] exp_q[$];

  pmod_pixel_streamer_if bus();

  pmod_pixel_streamer #(
    .FIFO_DEPTH_G (DEPTH),
    .SETUP_HOLD_G (SH),
    .ACK_TIMEOUT_G(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .overflow_o  (ovf),
    .timeout_o   (tmo),
    .fifo_level_o(lvl)
  );

  always #5 clk = ~clk;

  // Receiver: ack mirrors strobe shortly after each clock edge when enabled
  always @(posedge clk) begin
    #3;
    bus.pmod_ack_i = ack_en ? bus.pmod_stb_o : 1'b0;
  end

  // Monitor: compare each presented byte with the scoreboard head
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
    if (bus.pmod_stb_o && !stb_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected got sof=%0b data=%02h with nothing expected",
                 bus.pmod_sof_o, bus.pmod_data_o);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({bus.pmod_sof_o, bus.pmod_data_o} !== e) begin
          errors++;
          $display("FAIL mon_byte got sof=%0b data=%02h want sof=%0b data=%02h",
                   bus.pmod_sof_o, bus.pmod_data_o, e[8], e[7:0]);
        end
      end
    end
    stb_prev = bus.pmod_stb_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pix(input int addr, input logic [3:0] d);
    bus.pix_addr_i = 19'(addr);
    bus.pix_data_i = d;
    bus.pix_wr_i   = 1'b1;
    @(negedge clk);
    bus.pix_wr_i   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.pmod_stb_o || bus.pmod_ack_i) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(n < 3000), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_stb(output int k);
    k = 0;
    while (!bus.pmod_stb_o && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic count_high(output int h);
    h = 0;
    while (bus.pmod_stb_o && h < 200) begin
      @(negedge clk);
      h++;
    end
  endtask

  initial begin
    int k, h;
    rst = 1'b1;
    bus.pix_addr_i = '0;
    bus.pix_data_i = '0;
    bus.pix_wr_i   = 1'b0;
    bus.pmod_ack_i = 1'b0;
    #1;
    chk("rst_stb",  32'(bus.pmod_stb_o), 32'd0);
    chk("rst_data", 32'(bus.pmod_data_o), 32'd0);
    chk("rst_sof",  32'(bus.pmod_sof_o), 32'd0);
    chk("rst_ovf",  32'(ovf), 32'd0);
    chk("rst_tmo",  32'(tmo), 32'd0);
    chk("rst_lvl",  32'(lvl), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: first pair of a frame, latency and strobe width with fast ack
    ack_en = 1'b1;
    exp_q.push_back({1'b1, 8'hA3});
    pix(0, 4'h3);
    pix(1, 4'hA);
    wait_stb(k);
    chk("t1_stb_latency", 32'(k), 32'(SH + 1));
    count_high(h);
    chk("t1_stb_width", 32'(h), 32'd3);
    drain();

    // 5: stray odd write ignored; pending nibble replaced by a frame start
    exp_q.push_back({1'b1, 8'h92});
    pix(5, 4'h7);
    pix(6, 4'h1);
    pix(0, 4'h2);
    pix(1, 4'h9);
    drain();
    chk("t5_lvl", 32'(lvl), 32'd0);

    // 4: receiver never acks, byte aborted after the timeout
    ack_en = 1'b0;
    exp_q.push_back({1'b0, 8'h65});
    pix(2, 4'h5);
    pix(3, 4'h6);
    wait_stb(k);
    count_high(h);
    chk("t4_stb_width", 32'(h), 32'(TO));
    chk("t4_timeout", 32'(tmo), 32'd1);
    exp_q.push_back({1'b0, 8'h21});
    pix(4, 4'h1);
    pix(5, 4'h2);
    wait_stb(k);
    chk("t4_next_byte", 32'(bus.pmod_stb_o), 32'd1);
    ack_en = 1'b1;
    drain();

    // 3: ack held off, 20 bytes offered: 1 in flight + 16 queued, 3 dropped
    ack_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 17) exp_q.push_back({1'b0, ~4'(i), 4'(i)});
      pix(100 + 2 * i, 4'(i));
      pix(101 + 2 * i, ~4'(i));
    end
    chk("t3_lvl_full", 32'(lvl), 32'(DEPTH));
    chk("t3_overflow", 32'(ovf), 32'd1);
    ack_en = 1'b1;
    drain();
    chk("t3_overflow_sticky", 32'(ovf), 32'd1);
    exp_q.push_back({1'b1, 8'h54});
    pix(0, 4'h4);
    pix(1, 4'h5);
    chk("t3_ovf_cleared", 32'(ovf), 32'd0);
    chk("t3_tmo_cleared", 32'(tmo), 32'd0);
    drain();

    // 2: short frame with paced writes, ideal receiver
    max_lvl = 0;
    for (int p = 0; p < 32; p++) begin
      exp_q.push_back({1'(p == 0), 4'(2 * p + 1), 4'(2 * p)});
      pix(2 * p, 4'(2 * p));
      pix(2 * p + 1, 4'(2 * p + 1));
      repeat (12) @(negedge clk);
    end
    drain();
    chk("t2_max_level", 32'(max_lvl), 32'd1);
    chk("t2_overflow", 32'(ovf), 32'd0);

    // 6: reset while strobing with three bytes queued
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 4'(i), 4'h3});
      pix(200 + 2 * i, 4'h3);
      pix(201 + 2 * i, 4'(i));
    end
    wait_stb(k);
    chk("t6_stb_before", 32'(bus.pmod_stb_o), 32'd1);
    chk("t6_lvl_before", 32'(lvl), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_stb",  32'(bus.pmod_stb_o), 32'd0);
    chk("t6_rst_data", 32'(bus.pmod_data_o), 32'd0);
    chk("t6_rst_lvl",  32'(lvl), 32'd0);
    exp_q.delete();
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_idle_stb", 32'(bus.pmod_stb_o), 32'd0);
    chk("t6_idle_lvl", 32'(lvl), 32'd0);
    exp_q.push_back({1'b1, 8'hEF});
    pix(0, 4'hF);
    pix(1, 4'hE);
    drain();
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
